// File: rtl/cs_fixed_pkg.sv
// Shared fixed-point definitions for the column-norm / reciprocal datapath:
// FSM state encoding, Q4.12 constants, saturation value and default column length.
package cs_fixed_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StFin
  } state_e;

  localparam int unsigned Q_FRAC        = 12;
  localparam int unsigned ROUND_HALF    = 2048;
  localparam logic [15:0] SAT_VAL       = 16'hFFFF;
  localparam int unsigned N_LEN_DEFAULT = 64;

endpackage

// File: rtl/sq_acc.sv
// Square-and-accumulate datapath: adds s_i*s_i (unsigned Q8.24) into a wide sum.
module sq_acc
  import cs_fixed_pkg::*;
#(
  parameter int unsigned AccW = 42
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [15:0]     s_i,
  output logic [AccW-1:0] acc_o
);

  logic [AccW-1:0] acc_q, acc_d;
  logic [31:0]     prod;

  // (-8.0)^2 = 2^30 still fits, so the 32-bit product is always non-negative.
  assign prod = 32'($signed(s_i) * $signed(s_i));

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AccW'(prod);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/col_norm_acc.sv
// Column energy accumulator: sums squares of N_LEN Q4.12 samples, rounds/saturates to
// unsigned Q4.12. Optional NORM_ZERO_GUARD_EN forces a zero result to 1 and adds zero_out.
module col_norm_acc
  import cs_fixed_pkg::*;
#(
  parameter int unsigned N_LEN = N_LEN_DEFAULT,
  parameter int unsigned ACC_W = 42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] s_in,
  input  logic        s_valid,
  output logic [15:0] d_out,
  output logic        flag_out,
  output logic        busy,
  output logic        sat_out
`ifdef NORM_ZERO_GUARD_EN
  ,
  output logic        zero_out
`endif
);

  localparam int unsigned   CntW    = $clog2(N_LEN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(N_LEN - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc, rounded;
  logic              acc_clr, acc_en;
  logic [15:0]       d_q, d_d, res;
  logic              sat_q, sat_d, flag_q, flag_d, res_sat;
  logic              unused_lsb;
`ifdef NORM_ZERO_GUARD_EN
  logic              zero_q, zero_d;
`endif

  sq_acc #(
    .AccW (ACC_W)
  ) u_sq_acc (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .s_i   (s_in),
    .acc_o (acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (s_valid) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntLast) state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Round half-up at bit Q_FRAC; anything above the 16 result bits saturates.
  assign rounded    = acc + ACC_W'(ROUND_HALF);
  assign res_sat    = |rounded[ACC_W-1:Q_FRAC+16];
  assign res        = res_sat ? SAT_VAL : rounded[Q_FRAC+15:Q_FRAC];
  assign unused_lsb = ^rounded[Q_FRAC-1:0];

  always_comb begin
    d_d    = d_q;
    sat_d  = sat_q;
    flag_d = 1'b0;
`ifdef NORM_ZERO_GUARD_EN
    zero_d = zero_q;
`endif
    if (state_q == StFin) begin
      d_d    = res;
      sat_d  = res_sat;
      flag_d = 1'b1;
`ifdef NORM_ZERO_GUARD_EN
      zero_d = (res == 16'h0000);
      if (res == 16'h0000) d_d = 16'h0001;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      d_q     <= '0;
      sat_q   <= 1'b0;
      flag_q  <= 1'b0;
`ifdef NORM_ZERO_GUARD_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      sat_q   <= sat_d;
      flag_q  <= flag_d;
`ifdef NORM_ZERO_GUARD_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign d_out    = d_q;
  assign sat_out  = sat_q;
  assign flag_out = flag_q;
  assign busy     = (state_q != StIdle);
`ifdef NORM_ZERO_GUARD_EN
  assign zero_out = zero_q;
`endif

endmodule

// File: tb/tb_col_norm_acc.sv
// Randomized bench for col_norm_acc with three instances (N_LEN = 4, 1, 64) checked
// against a sum-of-squares reference model; honours NORM_ZERO_GUARD_EN.
module tb_col_norm_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [2:0]            en_a, sv_a, flag_a, busy_a, sat_a;
  logic [2:0][15:0]      si_a, d_a;
`ifdef NORM_ZERO_GUARD_EN
  logic [2:0]            zero_a;
`endif

  int nl [3] = '{4, 1, 64};
  int n_checks = 0;
  int n_pass   = 0;

  col_norm_acc #(.N_LEN(4), .ACC_W(42)) u_dut4 (
    .clk(clk), .rst(rst), .en(en_a[0]), .s_in(si_a[0]), .s_valid(sv_a[0]),
    .d_out(d_a[0]), .flag_out(flag_a[0]), .busy(busy_a[0]), .sat_out(sat_a[0])
`ifdef NORM_ZERO_GUARD_EN
    , .zero_out(zero_a[0])
`endif
  );

  col_norm_acc #(.N_LEN(1), .ACC_W(42)) u_dut1 (
    .clk(clk), .rst(rst), .en(en_a[1]), .s_in(si_a[1]), .s_valid(sv_a[1]),
    .d_out(d_a[1]), .flag_out(flag_a[1]), .busy(busy_a[1]), .sat_out(sat_a[1])
`ifdef NORM_ZERO_GUARD_EN
    , .zero_out(zero_a[1])
`endif
  );

  col_norm_acc #(.N_LEN(64), .ACC_W(42)) u_dut64 (
    .clk(clk), .rst(rst), .en(en_a[2]), .s_in(si_a[2]), .s_valid(sv_a[2]),
    .d_out(d_a[2]), .flag_out(flag_a[2]), .busy(busy_a[2]), .sat_out(sat_a[2])
`ifdef NORM_ZERO_GUARD_EN
    , .zero_out(zero_a[2])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: round half-up of the exact sum at 2^-12, saturate above 16 bits.
  task automatic ref_norm(input longint unsigned sum, output logic [15:0] d,
                          output logic sat, output logic zero);
    longint unsigned r;
    r    = sum + 64'd2048;
    zero = 1'b0;
    if (r >= (64'd1 << 28)) begin
      d   = 16'hFFFF;
      sat = 1'b1;
    end else begin
      d   = 16'(r / 64'd4096);
      sat = 1'b0;
    end
`ifdef NORM_ZERO_GUARD_EN
    if (d == 16'h0000) begin
      d    = 16'h0001;
      zero = 1'b1;
    end
`endif
  endtask

  // stall_mode: 0 none, 1 two idle cycles before each sample, 2 random 0..2.
  task automatic run_col(input int sel, input int stall_mode, input int amp,
                         input logic [15:0] fixed, input bit use_fixed,
                         input bit skip_start, input bit chain, input string tag);
    longint unsigned sum = 0;
    logic [15:0] ed, x;
    logic        es, ez;
    int          g, v;
    if (!skip_start) begin
      en_a[sel] = 1'b1;
      @(negedge clk);
      en_a[sel] = 1'b0;
    end
    check({tag, ".busy_start"}, 32'(busy_a[sel]), 32'd1);
    for (int i = 0; i < nl[sel]; i++) begin
      g = (stall_mode == 0) ? 0 : (stall_mode == 1) ? 2 : int'($urandom_range(0, 2));
      for (int k = 0; k < g; k++) begin
        sv_a[sel] = 1'b0;
        si_a[sel] = 16'($urandom);
        en_a[sel] = 1'($urandom);
        @(negedge clk);
        check({tag, ".busy_stall"}, 32'(busy_a[sel]), 32'd1);
      end
      if (use_fixed) begin
        x = fixed;
      end else begin
        v = int'($urandom_range(0, amp));
        if ($urandom_range(0, 1) == 1) v = -v;
        if (v > 32767) v = 32767;
        x = 16'(v);
      end
      sum += longint'($signed(x)) * longint'($signed(x));
      sv_a[sel] = 1'b1;
      si_a[sel] = x;
      en_a[sel] = 1'($urandom);
      @(negedge clk);
      check({tag, ".busy_acc"}, 32'(busy_a[sel]), 32'd1);
      check({tag, ".flag_early"}, 32'(flag_a[sel]), 32'd0);
    end
    sv_a[sel] = 1'b0;
    en_a[sel] = 1'b0;
    @(negedge clk);
    ref_norm(sum, ed, es, ez);
    check({tag, ".flag"}, 32'(flag_a[sel]), 32'd1);
    check({tag, ".d_out"}, 32'(d_a[sel]), 32'(ed));
    check({tag, ".sat"}, 32'(sat_a[sel]), 32'(es));
    check({tag, ".busy_done"}, 32'(busy_a[sel]), 32'd0);
`ifdef NORM_ZERO_GUARD_EN
    check({tag, ".zero"}, 32'(zero_a[sel]), 32'(ez));
`endif
    if (chain) en_a[sel] = 1'b1;
    @(negedge clk);
    en_a[sel] = 1'b0;
    check({tag, ".flag_clear"}, 32'(flag_a[sel]), 32'd0);
    check({tag, ".d_hold"}, 32'(d_a[sel]), 32'(ed));
    check({tag, ".sat_hold"}, 32'(sat_a[sel]), 32'(es));
    check({tag, ".busy_after"}, 32'(busy_a[sel]), chain ? 32'd1 : 32'd0);
  endtask

  initial begin
    int sel, amp_sel;
    int amps [4] = '{64, 1024, 8192, 32768};
    rst  = 1'b1;
    en_a = '0;
    sv_a = '0;
    si_a = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reset.d_out", 32'(d_a[i]), 32'd0);
      check("reset.flag", 32'(flag_a[i]), 32'd0);
      check("reset.busy", 32'(busy_a[i]), 32'd0);
      check("reset.sat", 32'(sat_a[i]), 32'd0);
    end

    run_col(0, 0, 0, 16'h1000, 1'b1, 1'b0, 1'b0, "unit");
    run_col(1, 0, 0, 16'h002D, 1'b1, 1'b0, 1'b0, "round_2d");
    run_col(1, 0, 0, 16'h002E, 1'b1, 1'b0, 1'b0, "round_2e");
    run_col(1, 0, 0, 16'h0040, 1'b1, 1'b0, 1'b0, "round_40");
    run_col(2, 0, 0, 16'h8000, 1'b1, 1'b0, 1'b0, "sat");
    run_col(2, 2, 0, 16'h0000, 1'b1, 1'b0, 1'b0, "zero_col");
    run_col(0, 1, 0, 16'h1000, 1'b1, 1'b0, 1'b0, "stall");

    // Abort a column after two samples.
    en_a[0] = 1'b1;
    @(negedge clk);
    en_a[0] = 1'b0;
    sv_a[0] = 1'b1;
    si_a[0] = 16'h7FFF;
    repeat (2) @(negedge clk);
    sv_a[0] = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.d_out", 32'(d_a[0]), 32'd0);
    check("abort.sat", 32'(sat_a[0]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort.flag", 32'(flag_a[0]), 32'd0);
      check("abort.busy", 32'(busy_a[0]), 32'd0);
      @(negedge clk);
    end
    run_col(0, 2, 0, 16'h0800, 1'b1, 1'b0, 1'b0, "after_abort");

    // en raised while flag_out is high starts the next column directly.
    run_col(0, 0, 1024, 16'h0000, 1'b0, 1'b0, 1'b1, "chain_a");
    run_col(0, 2, 8192, 16'h0000, 1'b0, 1'b1, 1'b0, "chain_b");

    for (int it = 0; it < 30; it++) begin
      sel     = int'($urandom_range(0, 2));
      amp_sel = int'($urandom_range(0, 3));
      run_col(sel, 2, amps[amp_sel], 16'h0000, 1'b0, 1'b0, 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/col_norm_acc.md
# col_norm_acc

Column energy accumulator feeding the reciprocal stage (`d_inv_syn`). Streams N_LEN signed Q4.12 samples of one measurement-matrix column, accumulates their squares at full precision, then rounds and saturates the sum to a 16-bit unsigned Q4.12 value. It presents that value on `d_out` with a one-cycle `flag_out` pulse, in the form `d_inv_syn` takes as `d_in`.

## Interface
- `N_LEN`, 64: samples per column; legal range 1..1024.
- `ACC_W`, 42: accumulator width in bits; must be ≥ 32 + ceil(log2(N_LEN)).
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: start request; sampled only in IDLE.
- `s_in` in 16: sample, signed two's-complement Q4.12.
- `s_valid` in 1: `s_in` is valid this cycle.
- `d_out` out 16: norm result, unsigned Q4.12; holds its value until the next result.
- `flag_out` out 1: one-cycle pulse when `d_out` updates.
- `busy` out 1: high in ACC and FIN.
- `sat_out` out 1: the last result saturated; holds with `d_out`.

## Operation
- FSM states: IDLE, ACC, FIN.
- IDLE:
  - On `en`=1: clear the accumulator and the sample counter, then go to ACC.
  - `s_valid` is ignored in IDLE.
- ACC:
  - On each edge with `s_valid`=1: acc += s_in*s_in (signed 16x16 product, 32-bit Q8.24, non-negative, zero-extended to ACC_W), and cnt += 1.
  - Cycles with `s_valid`=0 are stalls and change nothing.
  - When the sample accepted makes cnt equal N_LEN, go to FIN. That sample is included in the sum.
- FIN (one cycle):
  - r = acc + 2^11, giving round-half-up at bit 12.
  - If r[ACC_W-1:28] ≠ 0: `d_out`=16'hFFFF and `sat_out`=1.
  - Otherwise: `d_out`=r[27:12] and `sat_out`=0.
  - Assert `flag_out` and return to IDLE.
- `en` is ignored in ACC and FIN. There is no restart mid-column.
- Square of −8.0 (16'h8000) is +64.0 and must not wrap. The product is treated as unsigned 32-bit.
- In IDLE, `s_valid` and `s_in` are don't-care.

## Timing
- Reset values: `d_out`=0, `flag_out`=0, `busy`=0, `sat_out`=0. The FSM resets to IDLE, and the accumulator and counter reset to 0.
- `rst` asserted in any state aborts the column. No `flag_out` is produced for the aborted column.
- `en` sampled at edge k puts the FSM in ACC after edge k. The first sample can be accepted at edge k+1.
- The last sample is accepted at edge m and the FSM is in FIN after m. On edge m+1, `d_out` and `sat_out` update and `flag_out` rises. `flag_out` clears at edge m+2.
- Minimum column time is N_LEN+2 cycles from `en` to IDLE. Gaps in `s_valid` add one cycle each.
- `en` may be asserted in the cycle `flag_out` is high; that column starts in the same way.
- `flag_out` high for more than one cycle is a failure.

## Configuration
- `NORM_ZERO_GUARD_EN` defined:
  - In FIN, a rounded result of 16'h0000 is replaced by 16'h0001.
  - An extra output `zero_out` (1 bit, reset 0) is set for that result and holds with `d_out`.
  - This keeps the log2/reciprocal path downstream from ever seeing zero.
- `NORM_ZERO_GUARD_EN` undefined: a zero result is passed through as 16'h0000, and `zero_out` does not exist.

## Structure
- Shared package `cs_fixed_pkg` holds:
  - the state encoding (IDLE/ACC/FIN);
  - Q4.12 constants: `Q_FRAC`=12, `ROUND_HALF`=2^11;
  - saturation value 16'hFFFF;
  - the default N_LEN.
- One sub-module, `sq_acc`: the square-and-accumulate datapath (clear, enable, 16-bit input, ACC_W-bit sum).
- The FSM, counter, and round/saturate logic stay in `col_norm_acc`.

## Test plan
- Unit column: N_LEN=4, `en` then four samples of 16'h1000 back-to-back. Expect `d_out`=16'h4000, `sat_out`=0, and `flag_out` one cycle, two edges after the last sample.
- Rounding at N_LEN=1:
  - sample 16'h002D gives `d_out`=16'h0000;
  - sample 16'h002E gives 16'h0001;
  - sample 16'h0040 gives 16'h0001.
- Saturation: N_LEN=64, all samples 16'h8000. Expect `d_out`=16'hFFFF and `sat_out`=1. Then a column of 16'h0000 clears `sat_out` to 0.
- Stalls: N_LEN=4, samples 16'h1000 with `s_valid` high only on every third cycle. Expect `d_out`=16'h4000 and `flag_out` two edges after the fourth valid sample. `busy` stays high throughout.
- Reset and ignored `en`: `rst` after 2 of 4 samples gives all outputs 0 and no `flag_out`. A new `en` plus 4×16'h0800 gives 16'h1000. `en` pulses during ACC have no effect.
- Zero guard: a column of all 16'h0000 gives `d_out`=16'h0001 and `zero_out`=1 with `NORM_ZERO_GUARD_EN` defined, and `d_out`=16'h0000 without it.
